regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count (power of 2, >=4); AW = log2(DEPTH).
REQ-003 SHALL have parameter NREAD, default 2, meaning number of combinational read ports (1..4).
REQ-004 Clock and reset: one clock `clk`, rising edge; reset `rst_n`, asynchronous, active-low.
REQ-005 Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `rd_addr` in NREAD*AW: packed read addresses, port i at [i*AW +: AW].
- `rd_data` out NREAD*WIDTH: packed read data.
- `rd_busy` out NREAD: source register has a pending write.
- `we` in 1: writeback request.
- `wa` in AW: writeback address.
- `wd` in WIDTH: writeback data.
- `wr_stall` in 1: suppresses writeback when high.
- `iss_valid` in 1: an instruction with a destination register issues.
- `iss_addr` in AW: destination register of the issuing instruction.
- `flush` in 1: synchronous clear of all pending bits.
- `pend_cnt` out AW+1: number of set pending bits.
- `any_busy` out 1: OR of rd_busy.

Function
REQ-006 Register 0 SHALL read as 0, ignore writes, and never become pending.
REQ-007 commit = we & ~wr_stall & (wa != 0); on commit, rf[wa] <= wd at the rising clk edge.
REQ-008 rd_data port i SHALL be combinational from rf[rd_addr_i] with no cycle latency.
REQ-009 Scoreboard pending[DEPTH-1:1]: iss_valid & (iss_addr != 0) & ~flush SHALL set pending[iss_addr] next edge.
REQ-010 Commit SHALL clear pending[wa] next edge; a set and a clear to the same address in one cycle: set wins.
REQ-011 flush SHALL clear every pending bit next edge and override same-cycle issue; a same-cycle commit still writes rf.
REQ-012 rd_busy[i] SHALL be pending[rd_addr_i]; it is 0 when rd_addr_i == 0.
REQ-013 pend_cnt SHALL equal the popcount of pending, updated registered alongside pending; it saturates naturally at DEPTH-1 and SHALL never wrap.
REQ-014 Issue to an already-pending address SHALL leave the bit set (no count change); commit to a non-pending address SHALL only write rf.
REQ-015 any_busy SHALL be the combinational OR of rd_busy.

Reset
REQ-016 rst_n low SHALL asynchronously clear all rf entries to 0, all pending bits to 0, and pend_cnt to 0.
REQ-017 While rst_n is low: rd_data reads 0, rd_busy = 0, any_busy = 0; commit and issue are ignored.
REQ-018 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high; reset mid-operation discards all pending state.

Configuration
REQ-019 Macro REGFILE_SB_BYPASS_EN.
- Defined: when commit and wa == rd_addr_i (nonzero), rd_data_i SHALL return wd in the same cycle, and rd_busy_i SHALL be 0 unless a same-cycle issue targets that address.
- Undefined: rd_data_i returns the old rf value, and rd_busy_i reflects pending before the edge.

Verification
REQ-020 Reset, then read all addresses on both ports -> rd_data 0; rd_busy 0; pend_cnt 0.
REQ-021 Issue r5; next cycle read r5 -> rd_busy 1, pend_cnt 1. Commit r5=0xDEADBEEF -> after edge: busy 0, data 0xDEADBEEF, pend_cnt 0.
REQ-022 Same-cycle commit r7=0x12345678 and read r7.
- Bypass defined -> rd_data 0x12345678, busy 0.
- Bypass undefined -> old value, busy 1.
REQ-023 Same cycle: issue r3 and commit r3 while r3 pending -> r3 stays pending, pend_cnt unchanged. Write r0=0xFFFFFFFF -> r0 reads 0.
REQ-024 Issue r1, r2, r4; then flush with issue r6 in the same cycle -> pend_cnt 0, r6 not pending.
REQ-025 Issue r9; assert rst_n low mid-cycle -> immediately pending cleared, rf 0; commit with wr_stall=1 -> no write, pending unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with one write-back port, NREAD combinational read ports and a pending-write scoreboard.
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle write-back data (and busy release) to the read ports.
module regfile_sb #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREAD = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   we,
   input  logic [AW-1:0]          wa,
   input  logic [WIDTH-1:0]       wd,
   input  logic                   wr_stall,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_addr,
   input  logic                   flush,
   output logic [AW:0]            pend_cnt,
   output logic                   any_busy
);

   logic [WIDTH-1:0] r_rf [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic [AW:0]      r_cnt;
   logic [DEPTH-1:0] w_pend_nxt;
   logic [AW:0]      w_cnt_nxt;
   logic             w_commit;
   logic             w_set;

   // rst_n gating keeps forwarded data and busy quiet while reset is held.
   assign w_commit = rst_n & we & ~wr_stall & (wa != '0);
   assign w_set    = rst_n & iss_valid & ~flush & (iss_addr != '0);

   always_comb begin
      w_pend_nxt = r_pend;
      if (w_commit) w_pend_nxt[wa] = 1'b0;
      if (flush) w_pend_nxt = '0;
      else if (w_set) w_pend_nxt[iss_addr] = 1'b1;
      w_pend_nxt[0] = 1'b0;
      w_cnt_nxt = '0;
      for (int i = 1; i < DEPTH; i++) begin
         w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_commit) r_rf[wa] <= wd;
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign pend_cnt = r_cnt;

   // Entry 0 is never written and never pending, so it reads 0 / not busy for free.
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = rd_addr[g*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
      logic w_hit;
      assign w_hit = w_commit & (wa == w_ra);
      assign rd_data[g*WIDTH +: WIDTH] = w_hit ? wd : r_rf[w_ra];
      assign rd_busy[g] = w_hit ? (w_set & (iss_addr == w_ra)) : r_pend[w_ra];
`else
      assign rd_data[g*WIDTH +: WIDTH] = r_rf[w_ra];
      assign rd_busy[g] = r_pend[w_ra];
`endif
   end

   assign any_busy = |rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors, a spec-level model checked every negedge, plus literal expectations.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic        wr_stall = 1'b0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_addr = '0;
   logic        flush = 1'b0;
   logic [5:0]  pend_cnt;
   logic        any_busy;

   int n_vec = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .we(we), .wa(wa), .wd(wd), .wr_stall(wr_stall), .iss_valid(iss_valid),
      .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt), .any_busy(any_busy)
   );

   // Architectural model: register contents and set of in-flight destinations.
   logic [31:0] m_rf [32];
   logic        m_pend [32];
   wire         m_commit = we && !wr_stall && (wa != 5'd0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_rf[i]   <= '0;
            m_pend[i] <= 1'b0;
         end
      end else begin
         if (m_commit) begin
            m_rf[wa]   <= wd;
            m_pend[wa] <= 1'b0;
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
         end else if (iss_valid && iss_addr != 5'd0) begin
            m_pend[iss_addr] <= 1'b1;
         end
      end
   end

   function automatic logic exp_hit(input logic [4:0] a);
      return BYP && rst_n && m_commit && (wa == a);
   endfunction

   function automatic logic [31:0] exp_data(input int p);
      logic [4:0] a = rd_addr[p*5 +: 5];
      if (!rst_n || a == 5'd0) return '0;
      if (exp_hit(a)) return wd;
      return m_rf[a];
   endfunction

   function automatic logic exp_busy(input int p);
      logic [4:0] a = rd_addr[p*5 +: 5];
      if (!rst_n || a == 5'd0) return 1'b0;
      if (exp_hit(a)) return iss_valid && !flush && (iss_addr == a);
      return m_pend[a];
   endfunction

   function automatic logic [5:0] exp_cnt();
      int n = 0;
      for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
      return 6'(n);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         chk("model_rd_data", 64'(rd_data[p*32 +: 32]), 64'(exp_data(p)));
         chk("model_rd_busy", 64'(rd_busy[p]), 64'(exp_busy(p)));
      end
      chk("model_pend_cnt", 64'(pend_cnt), 64'(exp_cnt()));
      chk("model_any_busy", 64'(any_busy), 64'(exp_busy(0) | exp_busy(1)));
   end

   task automatic idle();
      we = 1'b0; wr_stall = 1'b0; iss_valid = 1'b0; flush = 1'b0;
   endtask
   task automatic at_neg(); @(negedge clk); endtask
   task automatic nxt(); @(posedge clk); #1; endtask
   task automatic commit(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
   endtask
   task automatic issue(input logic [4:0] a);
      iss_valid = 1'b1; iss_addr = a;
   endtask

   initial begin
      // Reset held with write and issue requests present: both ignored.
      #2 rst_n = 1'b0;
      commit(5'd3, 32'hFF); issue(5'd4); rd_addr = {5'd4, 5'd3};
      at_neg();
      chk("rst_data", 64'(rd_data), 64'h0);
      chk("rst_busy", 64'(rd_busy), 64'h0);
      chk("rst_cnt", 64'(pend_cnt), 64'h0);
      @(posedge clk); #1;
      idle(); rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         at_neg();
         chk("reset_rd_zero", 64'(rd_data), 64'h0);
         chk("reset_busy_zero", 64'({any_busy, rd_busy}), 64'h0);
         nxt();
      end

      // Issue r5, then commit 0xDEADBEEF.
      issue(5'd5); nxt(); idle();
      rd_addr = {5'd0, 5'd5};
      at_neg();
      chk("r5_busy", 64'(rd_busy), 64'h1);
      chk("r5_cnt", 64'(pend_cnt), 64'h1);
      chk("r5_any", 64'(any_busy), 64'h1);
      nxt();
      commit(5'd5, 32'hDEADBEEF);
      nxt(); idle();
      at_neg();
      chk("r5_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("r5_clear", 64'(rd_busy), 64'h0);
      chk("r5_cnt0", 64'(pend_cnt), 64'h0);

      // r7: commit to non-pending, then pending, then same-cycle commit+read on port 1.
      nxt();
      commit(5'd7, 32'h11111111); nxt(); idle();
      issue(5'd7); nxt(); idle();
      rd_addr = {5'd7, 5'd0};
      commit(5'd7, 32'h12345678);
      at_neg();
`ifdef REGFILE_SB_BYPASS_EN
      chk("r7_same_data", 64'(rd_data[63:32]), 64'h12345678);
      chk("r7_same_busy", 64'(rd_busy), 64'h0);
`else
      chk("r7_same_data", 64'(rd_data[63:32]), 64'h11111111);
      chk("r7_same_busy", 64'(rd_busy), 64'h2);
      chk("r7_same_any", 64'(any_busy), 64'h1);
`endif
      nxt(); idle();
      at_neg();
      chk("r7_after", 64'(rd_data[63:32]), 64'h12345678);
      chk("r7_cnt", 64'(pend_cnt), 64'h0);

      // r3: issue and commit together while pending -> stays pending, data written.
      nxt();
      issue(5'd3); nxt(); idle();
      issue(5'd3); commit(5'd3, 32'hAAAA5555); nxt(); idle();
      rd_addr = {5'd0, 5'd3};
      at_neg();
      chk("r3_busy", 64'(rd_busy), 64'h1);
      chk("r3_cnt", 64'(pend_cnt), 64'h1);
      chk("r3_data", 64'(rd_data[31:0]), 64'hAAAA5555);
      nxt();
      commit(5'd3, 32'h3); nxt(); idle();
      // r0 write and issue both ignored.
      commit(5'd0, 32'hFFFFFFFF); issue(5'd0); nxt(); idle();
      rd_addr = {5'd3, 5'd0};
      at_neg();
      chk("r0_data", 64'(rd_data[31:0]), 64'h0);
      chk("r0_busy", 64'(rd_busy), 64'h0);
      chk("r3_cleared", 64'(pend_cnt), 64'h0);

      // Flush beats same-cycle issue; same-cycle commit still writes.
      nxt();
      issue(5'd1); nxt(); issue(5'd2); nxt(); issue(5'd4); nxt(); idle();
      at_neg();
      chk("three_pend", 64'(pend_cnt), 64'h3);
      nxt();
      flush = 1'b1; issue(5'd6); commit(5'd10, 32'h0BADF00D); nxt(); idle();
      rd_addr = {5'd10, 5'd6};
      at_neg();
      chk("flush_cnt", 64'(pend_cnt), 64'h0);
      chk("flush_r6", 64'(rd_busy), 64'h0);
      chk("flush_wr", 64'(rd_data[63:32]), 64'h0BADF00D);

      // Fill every entry: count tops out at 31, re-issue does not move it.
      nxt();
      for (int a = 1; a < 32; a++) begin
         issue(5'(a)); nxt();
      end
      issue(5'd31); nxt(); idle();
      rd_addr = {5'd31, 5'd0};
      at_neg();
      chk("full_cnt", 64'(pend_cnt), 64'd31);
      chk("full_busy", 64'(rd_busy), 64'h2);
      nxt();
      flush = 1'b1; nxt(); idle();

      // Stalled commit neither writes nor clears; then reset mid-cycle.
      commit(5'd9, 32'h99); nxt(); idle();
      issue(5'd9); nxt(); idle();
      commit(5'd9, 32'h1234); wr_stall = 1'b1; nxt(); idle();
      rd_addr = {5'd0, 5'd9};
      at_neg();
      chk("stall_data", 64'(rd_data[31:0]), 64'h99);
      chk("stall_busy", 64'(rd_busy), 64'h1);
      chk("stall_cnt", 64'(pend_cnt), 64'h1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(rd_busy), 64'h0);
      chk("mid_rst_cnt", 64'(pend_cnt), 64'h0);
      chk("mid_rst_data", 64'(rd_data[31:0]), 64'h0);
      at_neg();
      @(posedge clk); #1;
      rst_n = 1'b1;
      nxt();
      at_neg();
      chk("post_rst_r9", 64'(rd_data[31:0]), 64'h0);
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
